// File: rtl/a_sram_pkg.sv
// Shared parameters and FSM state type for the A-operand SRAM sequencer.
package a_sram_pkg;

    localparam int MATRIX_SIZE = 64;
    localparam int LANE_NUM    = 16;
    localparam int DEPTH       = (MATRIX_SIZE / LANE_NUM) * (MATRIX_SIZE / 32);
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int DATA_W      = 264;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/a_sram_arb.sv
// Two-requester grant logic: a read of a resident matrix beats a reload.
module a_sram_arb (
    input  logic load_req,
    input  logic read_req,
    input  logic a_valid,
    input  logic idle,
    output logic grant_load,
    output logic grant_read
);

    // A read request only counts once there is a matrix to read.
    assign grant_read = idle & read_req & a_valid;
    assign grant_load = idle & load_req & ~grant_read;

endmodule

// File: rtl/a_sram_ctrl.sv
// Sequencer for the 16-bank A-operand SRAM: arbitrates loader writes against
// compute reads, walks bank addresses, and tracks matrix residency.
module a_sram_ctrl
    import a_sram_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic                read_req,
    input  logic                rd_ready,
    input  logic                invalidate,
    output logic                load_gnt,
    output logic                read_gnt,
    output logic [LANE_NUM-1:0] wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic                rd_last,
    output logic                load_done,
    output logic                read_done,
    output logic                a_valid,
    output logic                busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              load_gnt_q, load_gnt_d;
    logic              read_gnt_q, read_gnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              load_done_q, load_done_d;
    logic              read_done_q, read_done_d;
    logic              a_valid_q, a_valid_d;

    logic arb_idle;
    logic grant_load;
    logic grant_read;

    // No new grant in the completion cycle; arbitration resumes one cycle later.
    assign arb_idle = (state_q == IDLE) & ~load_done_q & ~read_done_q;

    a_sram_arb u_arb (
        .load_req   (load_req),
        .read_req   (read_req),
        .a_valid    (a_valid_q),
        .idle       (arb_idle),
        .grant_load (grant_load),
        .grant_read (grant_read)
    );

    assign rd_en = (state_q == READ) & rd_ready;

    always_comb begin
        // NOTE: every next-state value gets a default first so no branch infers a latch.
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        load_gnt_d  = 1'b0;
        read_gnt_d  = 1'b0;
        load_done_d = 1'b0;
        read_done_d = 1'b0;
        a_valid_d   = a_valid_q;
        rd_valid_d  = rd_en;
        rd_last_d   = rd_en & (rd_addr_q == LAST_ADDR);

        // A load in flight, or one completing this cycle, outranks invalidate.
        if (invalidate && state_q != LOAD && !load_done_q) begin
            a_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_load) begin
                    state_d    = LOAD;
                    wr_addr_d  = '0;
                    load_gnt_d = 1'b1;
                    a_valid_d  = 1'b0;
                end else if (grant_read) begin
                    state_d    = READ;
                    rd_addr_d  = '0;
                    read_gnt_d = 1'b1;
                end
            end
            LOAD: begin
                if (wr_addr_q == LAST_ADDR) begin
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                    a_valid_d   = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end
            end
            READ: begin
                if (rd_en) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                state_d     = IDLE;
                read_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every flop, counters included.
        if (rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            load_gnt_q  <= 1'b0;
            read_gnt_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            load_done_q <= 1'b0;
            read_done_q <= 1'b0;
            a_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            load_gnt_q  <= load_gnt_d;
            read_gnt_q  <= read_gnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            load_done_q <= load_done_d;
            read_done_q <= read_done_d;
            a_valid_q   <= a_valid_d;
        end
    end

    assign load_gnt  = load_gnt_q;
    assign read_gnt  = read_gnt_q;
    assign wr_en     = {LANE_NUM{state_q == LOAD}};
    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign load_done = load_done_q;
    assign read_done = read_done_q;
    assign a_valid   = a_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_a_sram_ctrl.sv
// Directed bench for a_sram_ctrl: a vector table for load+read, then hand sequences.
module tb_a_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req, read_req, rd_ready, invalidate;
    logic        load_gnt, read_gnt;
    logic [15:0] wr_en;
    logic [2:0]  wr_addr, rd_addr;
    logic        rd_en, rd_valid, rd_last, load_done, read_done, a_valid, busy;

    int n_tests = 0;
    int n_fail  = 0;

    a_sram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .read_req   (read_req),
        .rd_ready   (rd_ready),
        .invalidate (invalidate),
        .load_gnt   (load_gnt),
        .read_gnt   (read_gnt),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .load_done  (load_done),
        .read_done  (read_done),
        .a_valid    (a_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        lg;
        logic        rg;
        logic [15:0] wen;
        logic [2:0]  wa;
        logic        ren;
        logic [2:0]  ra;
        logic        rv;
        logic        rl;
        logic        ld;
        logic        rd;
        logic        av;
        logic        bsy;
    } out_t;

    typedef struct {
        logic rst;
        logic lr;
        logic rr;
        logic rdy;
        logic inv;
        out_t exp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    localparam int S_LOAD_GNT  = 0;
    localparam int S_READ_GNT  = 1;
    localparam int S_LOAD_DONE = 2;
    localparam int S_READ_DONE = 3;

    function automatic out_t o(input logic lg, input logic rg, input logic wen,
                               input int wa, input logic ren, input int ra,
                               input logic rv, input logic rl, input logic ld,
                               input logic rd, input logic av, input logic bsy);
        out_t r;
        r.lg  = lg;
        r.rg  = rg;
        r.wen = {16{wen}};
        r.wa  = 3'(wa);
        r.ren = ren;
        r.ra  = 3'(ra);
        r.rv  = rv;
        r.rl  = rl;
        r.ld  = ld;
        r.rd  = rd;
        r.av  = av;
        r.bsy = bsy;
        return r;
    endfunction

    function automatic vec_t mk(input logic r, input logic lr, input logic rr,
                                input logic rdy, input logic inv, input out_t e);
        vec_t v;
        v.rst = r;
        v.lr  = lr;
        v.rr  = rr;
        v.rdy = rdy;
        v.inv = inv;
        v.exp = e;
        return v;
    endfunction

    function automatic out_t cur_out();
        out_t r;
        r = {load_gnt, read_gnt, wr_en, wr_addr, rd_en, rd_addr,
             rd_valid, rd_last, load_done, read_done, a_valid, busy};
        return r;
    endfunction

    function automatic logic sig(input int which);
        case (which)
            S_LOAD_GNT:  return load_gnt;
            S_READ_GNT:  return read_gnt;
            S_LOAD_DONE: return load_done;
            default:     return read_done;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input int max, input string name);
        for (int i = 0; i < max && !sig(which); i++) tick();
        check(name, 32'(sig(which)), 32'd1);
    endtask

    // Vector k: inputs driven during cycle k, outputs observed during cycle k.
    task automatic fill_vectors();
        vecs[0]  = mk(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(0, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs[2]  = mk(0, 0, 0, 0, 0, o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 1; k < 8; k++)
            vecs[2+k] = mk(0, 0, 0, 0, 0, o(0, 0, 1, k, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs[10] = mk(0, 0, 1, 0, 0, o(0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs[11] = mk(0, 0, 1, 1, 0, o(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs[12] = mk(0, 0, 0, 1, 0, o(0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1, 1));
        for (int k = 1; k < 8; k++)
            vecs[12+k] = mk(0, 0, 0, 1, 0, o(0, 0, 0, 7, 1, k, 1, 0, 0, 0, 1, 1));
        vecs[20] = mk(0, 0, 0, 1, 0, o(0, 0, 0, 7, 0, 7, 1, 1, 0, 0, 1, 1));
        vecs[21] = mk(0, 0, 0, 1, 0, o(0, 0, 0, 7, 0, 7, 0, 0, 0, 1, 1, 0));
    endtask

    logic pat[4];
    logic in_read, done;
    int   exp_addr, beats;

    initial begin
        rst = 1'b1; load_req = 1'b0; read_req = 1'b0; rd_ready = 1'b0; invalidate = 1'b0;
        fill_vectors();
        tick();
        tick();

        // Table: reset state, full load, then full read with rd_ready held high.
        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst; load_req = vecs[i].lr; read_req = vecs[i].rr;
            rd_ready = vecs[i].rdy; invalidate = vecs[i].inv;
            #1;
            check($sformatf("vec%0d", i), 32'(cur_out()), 32'(vecs[i].exp));
            tick();
        end

        // Read request with no resident matrix stays pending, then is served after a load.
        rst = 1'b1; load_req = 1'b0; read_req = 1'b0; rd_ready = 1'b0;
        tick();
        rst = 1'b0;
        read_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("pend_no_gnt", 32'(read_gnt | busy), 32'd0);
        end
        load_req = 1'b1;
        wait_for(S_LOAD_GNT, 10, "pend_load_gnt");
        check("pend_no_rgnt_in_load", 32'(read_gnt), 32'd0);
        load_req = 1'b0;
        wait_for(S_LOAD_DONE, 20, "pend_load_done");
        check("pend_av_after_load", 32'(a_valid), 32'd1);
        tick();
        check("pend_rgnt_arb_cycle", 32'(read_gnt), 32'd0);
        tick();
        check("pend_rgnt_2_after_done", 32'(read_gnt), 32'd1);
        read_req = 1'b0;
        rd_ready = 1'b1;
        wait_for(S_READ_DONE, 20, "pend_read_done");

        // Back-pressure: rd_ready pattern 1,0,0,1 repeating, reference address model.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rd_ready = pat[0];
        read_req = 1'b1;
        tick();
        wait_for(S_READ_GNT, 10, "bp_read_gnt");
        read_req = 1'b0;
        exp_addr = 0; in_read = 1'b1; beats = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            rd_ready = pat[i % 4];
            #1;
            if (read_done) begin
                done = 1'b1;
            end else begin
                check("bp_rd_en", 32'(rd_en), 32'(in_read & rd_ready));
                if (in_read) check("bp_rd_addr", 32'(rd_addr), 32'(exp_addr));
                if (rd_valid) begin
                    beats++;
                    check("bp_rd_last", 32'(rd_last), 32'(beats == 8));
                end
                if (in_read && rd_ready) begin
                    if (exp_addr == 7) in_read = 1'b0;
                    else exp_addr++;
                end
                tick();
            end
        end
        check("bp_read_done_seen", 32'(done), 32'd1);
        check("bp_beat_count", 32'(beats), 32'd8);

        // Simultaneous requests with a resident matrix: read first, load after read_done+1.
        rd_ready = 1'b1;
        tick();
        load_req = 1'b1;
        read_req = 1'b1;
        tick();
        check("both_read_first", 32'(read_gnt), 32'd1);
        check("both_no_load_gnt", 32'(load_gnt), 32'd0);
        read_req = 1'b0;
        wait_for(S_READ_DONE, 20, "both_read_done");
        check("both_no_lgnt_at_done", 32'(load_gnt), 32'd0);
        tick();
        check("both_no_lgnt_arb", 32'(load_gnt), 32'd0);
        tick();
        check("both_lgnt", 32'(load_gnt), 32'd1);
        check("both_av_cleared", 32'(a_valid), 32'd0);
        load_req = 1'b0;
        tick();
        tick();
        check("both_av_mid_load", 32'(a_valid), 32'd0);
        wait_for(S_LOAD_DONE, 20, "both_load_done");
        check("both_av_after", 32'(a_valid), 32'd1);

        // Invalidate during a load and on load_done is overridden; in IDLE it clears.
        tick();
        load_req = 1'b1;
        tick();
        wait_for(S_LOAD_GNT, 10, "inv_load_gnt");
        load_req = 1'b0;
        tick();
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check("inv_mid_load_av", 32'(a_valid), 32'd0);
        wait_for(S_LOAD_DONE, 20, "inv_load_done");
        check("inv_av_at_done", 32'(a_valid), 32'd1);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check("inv_done_cycle_wins", 32'(a_valid), 32'd1);
        tick();
        check("inv_av_held", 32'(a_valid), 32'd1);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check("inv_idle_clears", 32'(a_valid), 32'd0);

        // Reset mid-load at wr_addr 4, then a fresh load restarts at address 0.
        load_req = 1'b1;
        tick();
        wait_for(S_LOAD_GNT, 10, "rst_load_gnt");
        load_req = 1'b0;
        for (int i = 0; i < 10 && wr_addr != 3'd4; i++) tick();
        check("rst_reach_addr4", 32'(wr_addr), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_all_zero", 32'(cur_out()), 32'd0);
        load_req = 1'b1;
        tick();
        check("rst_reload_gnt", 32'(load_gnt), 32'd1);
        check("rst_reload_addr0", 32'(wr_addr), 32'd0);
        check("rst_reload_av", 32'(a_valid), 32'd0);
        load_req = 1'b0;
        tick();
        check("rst_reload_addr1", 32'(wr_addr), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/a_sram_ctrl.md
Name: a_sram_ctrl

Overview:
Sequencer and arbiter for the 16-bank A-operand SRAM (264-bit words, 8 entries per bank for a 64x64 int8 matrix).
- Shares the SRAM between two requesters: the matrix loader (write side, driven by the a_sram_writer datapath) and the compute array (read side).
- Issues bank write/read enables and addresses.
- Tracks whether a valid matrix is resident.

Parameters:
MATRIX_SIZE, 64, square matrix dimension in int8 elements
LANE_NUM, 16, number of SRAM banks / lanes
DEPTH, 8, entries per bank = (MATRIX_SIZE/LANE_NUM)*(MATRIX_SIZE/32)
ADDR_W, 3, bank address width = clog2(DEPTH)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
load_req  in  1  loader requests a full-matrix write; level, held until load_gnt
read_req  in  1  compute requests a full-matrix read; level, held until read_gnt
rd_ready  in  1  consumer can accept a word this cycle
invalidate  in  1  discard resident matrix
load_gnt  out  1  one-cycle pulse, first write cycle
read_gnt  out  1  one-cycle pulse, first read-state cycle
wr_en  out  LANE_NUM  per-bank write enable
wr_addr  out  ADDR_W  write address, common to all banks
rd_en  out  1  read strobe to all banks
rd_addr  out  ADDR_W  read address
rd_valid  out  1  SRAM data_out valid (1-cycle read latency)
rd_last  out  1  qualifies final rd_valid beat
load_done  out  1  one-cycle pulse after final write
read_done  out  1  one-cycle pulse after final rd_valid
a_valid  out  1  matrix resident
busy  out  1  state != IDLE

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset, including mid-operation: next edge forces state=IDLE and zeroes every output, the counters and the pipeline regs. Any in-flight load leaves a_valid=0.
- FSM states: IDLE, LOAD, READ, DRAIN.
- IDLE arbitration, evaluated each cycle:
  - read_req is eligible only when a_valid=1.
  - If both load_req and eligible read_req are high, read wins: serve the resident matrix before overwriting it.
  - Else load_req wins.
  - read_req with a_valid=0 stays pending and is not an error.
- LOAD, granted at cycle T:
  - T+1..T+DEPTH: wr_en = all ones, wr_addr = 0..DEPTH-1, one per cycle, no stalls. load_gnt=1 at T+1 only.
  - T+DEPTH+1: state=IDLE, load_done=1, a_valid=1, busy=0.
  - a_valid is forced to 0 from T+1 until load completion.
- READ, granted at cycle T:
  - read_gnt=1 at T+1.
  - rd_en = (state==READ) & rd_ready, combinational from registered state.
  - rd_addr is registered and starts at 0. It increments only on cycles where rd_en=1; while rd_ready=0 it is held and rd_en=0.
- rd_valid and rd_last timing:
  - rd_valid is rd_en delayed one cycle.
  - rd_last = rd_valid for the beat at address DEPTH-1.
  - After issuing address DEPTH-1, the FSM enters DRAIN for one cycle, in which rd_valid=1 and rd_last=1.
  - The next cycle is IDLE with read_done=1.
- Invalidate:
  - Clears a_valid in IDLE, READ and DRAIN. A read in progress still completes.
  - Ignored in LOAD.
  - Asserted in the same cycle as load_done: a_valid=1, because load completion wins.
- No back-to-back grant in the cycle that load_done or read_done is high. Arbitration resumes the following cycle.
- Address counters are ADDR_W bits. Terminal count is compared against DEPTH-1, never by wrap. The counter clears to 0 on the next grant.

Decomposition:
- Shared package a_sram_pkg:
  - MATRIX_SIZE, LANE_NUM, DEPTH, ADDR_W.
  - DATA_W=264.
  - FSM state enum {IDLE, LOAD, READ, DRAIN}.
- One sub-module, a_sram_arb: two-requester grant logic. Inputs load_req, read_req, a_valid, idle; outputs grant_load, grant_read, mutually exclusive.

Test Plan:
1. Reset, then load_req=1 at cycle 2 → load_gnt at 3; wr_en=16'hFFFF with wr_addr 0..7 over cycles 3-10; load_done and a_valid=1 at 11.
2. read_req with a_valid=0 for 20 cycles → no read_gnt. Then complete a load → read_gnt 2 cycles after load_done. rd_addr 0..7 contiguous with rd_ready=1; rd_valid 1 cycle behind; rd_last on 8th beat; read_done the cycle after.
3. rd_ready toggled 1,0,0,1,... during READ → rd_en low and rd_addr held while 0. Exactly 8 rd_valid beats; addresses 0..7 in order with no skips.
4. load_req and read_req raised together with a_valid=1 → read granted first. Load granted after read_done+1. a_valid=0 during the load, 1 after.
5. invalidate pulsed mid-LOAD and in the same cycle as load_done → a_valid=1 after load. invalidate in IDLE → a_valid=0 next cycle.
6. rst asserted at write address 4 → all outputs 0 next cycle, a_valid=0. A new load restarts at wr_addr 0.
